// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop toward a stream of target bits and checks each transition via q/q_bar feedback.
// Optional build macro JK_TOGGLE_EN: changing transitions use toggle excitation (J=K=1) instead of set/reset.
module jk_excitation_driver #(
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    input  logic             q_bar_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             mismatch,
    output logic             integrity_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;

    localparam logic [3:0]       HOLD_LD = 4'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic       tgt_r;
    logic       cur_r;
    logic [3:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tgt_valid) state_nxt = DRIVE;
            DRIVE:   state_nxt = WAIT;
            WAIT:    if (hold_cnt <= 4'd1) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Excitation is decoded from the captured target/current pair and only presented while in DRIVE.
    always_comb begin
        j = 1'b0;
        k = 1'b0;
        if (state == DRIVE) begin
`ifdef JK_TOGGLE_EN
            j = tgt_r ^ cur_r;
            k = tgt_r ^ cur_r;
`else
            j = tgt_r & ~cur_r;
            k = cur_r & ~tgt_r;
`endif
        end
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r    <= 1'b0;
            cur_r    <= 1'b0;
            hold_cnt <= 4'd0;
        end else begin
            if (state == IDLE && tgt_valid) begin
                tgt_r <= tgt_bit;
                cur_r <= q_fb;
            end
            if (state == DRIVE) begin
                hold_cnt <= HOLD_LD;
            end else if (state == WAIT && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    // A clear on the same edge as a CHECK wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch      <= 1'b0;
            integrity_err <= 1'b0;
            xfer_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            mismatch <= (state == CHECK) && (q_fb != tgt_r);
            if (cnt_clr) begin
                integrity_err <= 1'b0;
                xfer_cnt      <= '0;
                err_cnt       <= '0;
            end else if (state == CHECK) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
                if (q_fb != tgt_r && err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (q_fb == q_bar_fb) begin
                    integrity_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: vector table, randomized transfers against a behavioural model,
// and a held-valid saturation run on a narrow-counter instance. Honours JK_TOGGLE_EN.
module tb_jk_excitation_driver;

    localparam int HA = 1;
    localparam int WA = 8;
    localparam int HB = 3;
    localparam int WB = 2;
`ifdef JK_TOGGLE_EN
    localparam logic TOG = 1'b1;
`else
    localparam logic TOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic valid_a, bit_a, rdy_a, q_a, qbar_a, j_a, k_a, busy_a, mis_a, ierr_a, clr_a;
    logic [WA-1:0] xfer_a, err_a;
    logic stuck_a, badqb_a;

    logic valid_b, bit_b, rdy_b, q_b, qbar_b, j_b, k_b, busy_b, mis_b, ierr_b, clr_b;
    logic [WB-1:0] xfer_b, err_b;
    logic stuck_b;

    jk_excitation_driver #(.CNT_W(WA), .HOLD_CYC(HA)) dut_a (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid_a), .tgt_bit(bit_a), .tgt_ready(rdy_a),
        .q_fb(q_a), .q_bar_fb(qbar_a), .j(j_a), .k(k_a), .busy(busy_a), .mismatch(mis_a),
        .integrity_err(ierr_a), .cnt_clr(clr_a), .xfer_cnt(xfer_a), .err_cnt(err_a)
    );

    jk_excitation_driver #(.CNT_W(WB), .HOLD_CYC(HB)) dut_b (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid_b), .tgt_bit(bit_b), .tgt_ready(rdy_b),
        .q_fb(q_b), .q_bar_fb(qbar_b), .j(j_b), .k(k_b), .busy(busy_b), .mismatch(mis_b),
        .integrity_err(ierr_b), .cnt_clr(clr_b), .xfer_cnt(xfer_b), .err_cnt(err_b)
    );

    // Flip-flop models: ideal JK behaviour unless held stuck; q_bar can be forced equal to q.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_a <= 1'b0;
        else if (!stuck_a) begin
            case ({j_a, k_a})
                2'b10:   q_a <= 1'b1;
                2'b01:   q_a <= 1'b0;
                2'b11:   q_a <= ~q_a;
                default: q_a <= q_a;
            endcase
        end
    end
    assign qbar_a = badqb_a ? q_a : ~q_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_b <= 1'b0;
        else if (!stuck_b) begin
            case ({j_b, k_b})
                2'b10:   q_b <= 1'b1;
                2'b01:   q_b <= 1'b0;
                2'b11:   q_b <= ~q_b;
                default: q_b <= q_b;
            endcase
        end
    end
    assign qbar_b = ~q_b;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete transfer on instance A; reports what was seen in DRIVE and after CHECK.
    task automatic applyStimulus(input logic t, input logic st, input logic bq, input logic clr,
                                 output logic oj, output logic ok, output logic obusy,
                                 output logic ordy, output logic omis, output logic omis2,
                                 output logic [31:0] oxf, output logic [31:0] oer, output logic oie);
        @(negedge clk);
        ordy    = rdy_a;
        valid_a = 1'b1;
        bit_a   = t;
        stuck_a = st;
        badqb_a = bq;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        oj      = j_a;
        ok      = k_a;
        obusy   = busy_a;
        repeat (HA + 1) @(posedge clk);
        @(negedge clk);
        clr_a = clr;
        @(posedge clk);
        #1;
        clr_a   = 1'b0;
        omis    = mis_a;
        oxf     = 32'(xfer_a);
        oer     = 32'(err_a);
        oie     = ierr_a;
        stuck_a = 1'b0;
        badqb_a = 1'b0;
        @(posedge clk);
        #1;
        omis2 = mis_a;
    endtask

    typedef struct {
        logic t, st, bq, clr;
        logic ej, ek, emis;
        int   exfer, eerr;
        logic eierr;
    } vec_t;

    function automatic vec_t mk(input logic t, input logic st, input logic bq, input logic clr,
                                input logic ej, input logic ek, input logic emis,
                                input int exfer, input int eerr, input logic eierr);
        vec_t v;
        v.t = t; v.st = st; v.bq = bq; v.clr = clr;
        v.ej = ej; v.ek = ek; v.emis = emis;
        v.exfer = exfer; v.eerr = eerr; v.eierr = eierr;
        return v;
    endfunction

    initial begin
        vec_t tbl[9];
        logic oj, ok, obusy, ordy, omis, omis2, oie;
        logic [31:0] oxf, oer;
        logic m_q, m_ierr, t, st, bq, clr, ej, ek, fin;
        int m_xfer, m_err, rdy_seen, mis_seen, bad_phase, bx, be;

        rst_n = 1'b0;
        valid_a = 0; bit_a = 0; clr_a = 0; stuck_a = 0; badqb_a = 0;
        valid_b = 0; bit_b = 0; clr_b = 0; stuck_b = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_j", j_a, 0);
        checkOutput("rst_k", k_a, 0);
        checkOutput("rst_ready", rdy_a, 1);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_mis", mis_a, 0);
        checkOutput("rst_ierr", ierr_a, 0);
        checkOutput("rst_xfer", xfer_a, 0);
        checkOutput("rst_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while the transfer sits in WAIT must abandon it without counting.
        @(negedge clk);
        valid_a = 1'b1;
        bit_a   = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        checkOutput("midrst_busy_pre", busy_a, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy_a, 0);
        checkOutput("midrst_ready", rdy_a, 1);
        checkOutput("midrst_jk", {j_a, k_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_xfer", xfer_a, 0);
        checkOutput("midrst_err", err_a, 0);
        checkOutput("midrst_mis", mis_a, 0);

        // Starting from q=0 and empty counters.
        tbl[0] = mk(1, 0, 0, 0, 1,   TOG, 0, 1, 0, 0);
        tbl[1] = mk(1, 0, 0, 0, 0,   0,   0, 2, 0, 0);
        tbl[2] = mk(0, 0, 0, 0, TOG, 1,   0, 3, 0, 0);
        tbl[3] = mk(0, 0, 0, 0, 0,   0,   0, 4, 0, 0);
        tbl[4] = mk(1, 1, 0, 0, 1,   TOG, 1, 5, 1, 0);
        tbl[5] = mk(1, 0, 1, 0, 1,   TOG, 0, 6, 1, 1);
        tbl[6] = mk(1, 0, 0, 0, 0,   0,   0, 7, 1, 1);
        tbl[7] = mk(0, 1, 0, 1, TOG, 1,   1, 0, 0, 0);
        tbl[8] = mk(0, 0, 0, 0, TOG, 1,   0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].t, tbl[i].st, tbl[i].bq, tbl[i].clr,
                          oj, ok, obusy, ordy, omis, omis2, oxf, oer, oie);
            checkOutput($sformatf("row%0d_ready", i), ordy, 1);
            checkOutput($sformatf("row%0d_j", i), oj, tbl[i].ej);
            checkOutput($sformatf("row%0d_k", i), ok, tbl[i].ek);
            checkOutput($sformatf("row%0d_busy", i), obusy, 1);
            checkOutput($sformatf("row%0d_mis", i), omis, tbl[i].emis);
            checkOutput($sformatf("row%0d_mis_next", i), omis2, 0);
            checkOutput($sformatf("row%0d_xfer", i), oxf, tbl[i].exfer);
            checkOutput($sformatf("row%0d_err", i), oer, tbl[i].eerr);
            checkOutput($sformatf("row%0d_ierr", i), oie, tbl[i].eierr);
        end

        // Randomized transfers against a model of the flip-flop outcome and counter rules.
        m_q = 1'b0; m_xfer = 1; m_err = 0; m_ierr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            t   = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) == 0);
            bq  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 9) == 0);
            if (TOG) begin
                ej = (t != m_q);
                ek = (t != m_q);
            end else begin
                ej = (t == 1'b1) && (m_q == 1'b0);
                ek = (t == 1'b0) && (m_q == 1'b1);
            end
            fin    = st ? m_q : t;
            m_xfer = (m_xfer + 1) % (1 << WA);
            if (fin != t) m_err = (m_err + 1 > (1 << WA) - 1) ? (1 << WA) - 1 : m_err + 1;
            if (bq) m_ierr = 1'b1;
            if (clr) begin
                m_xfer = 0; m_err = 0; m_ierr = 1'b0;
            end
            applyStimulus(t, st, bq, clr, oj, ok, obusy, ordy, omis, omis2, oxf, oer, oie);
            checkOutput($sformatf("rnd%0d_jk", i), {oj, ok}, {ej, ek});
            checkOutput($sformatf("rnd%0d_mis", i), omis, (fin != t));
            checkOutput($sformatf("rnd%0d_mis_next", i), omis2, 0);
            checkOutput($sformatf("rnd%0d_xfer", i), oxf, m_xfer);
            checkOutput($sformatf("rnd%0d_err", i), oer, m_err);
            checkOutput($sformatf("rnd%0d_ierr", i), oie, m_ierr);
            m_q = fin;
        end

        // Held valid on the narrow, long-hold instance with a stuck-at-0 flip-flop.
        rdy_seen = 0; mis_seen = 0; bad_phase = 0;
        @(negedge clk);
        valid_b = 1'b1;
        bit_b   = 1'b1;
        stuck_b = 1'b1;
        for (int i = 0; i <= 5 * (3 + HB); i++) begin
            if (i > 0) @(negedge clk);
            if (i < 5 * (3 + HB) && rdy_b) begin
                rdy_seen++;
                if (i % (3 + HB) != 0) bad_phase++;
            end
            if (mis_b) mis_seen++;
            if (i == 5 * (3 + HB) - 1) valid_b = 1'b0;
        end
        bx = 0; be = 0;
        for (int n = 0; n < 5; n++) begin
            bx = (bx + 1) % (1 << WB);
            be = (be + 1 > (1 << WB) - 1) ? (1 << WB) - 1 : be + 1;
        end
        checkOutput("held_ready_pulses", rdy_seen, 5);
        checkOutput("held_ready_phase", bad_phase, 0);
        checkOutput("held_mis_pulses", mis_seen, 5);
        checkOutput("sat_err", err_b, be);
        checkOutput("wrap_xfer", xfer_b, bx);
        checkOutput("held_ierr", ierr_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
